// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC controller: opcodes, ALU select codes,
// controller step states and the bundled strobe record.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_SHL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_MUL  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_JR   = 5'd20;
   localparam logic [4:0] OP_IN   = 5'd22;
   localparam logic [4:0] OP_MFHI = 5'd24;
   localparam logic [4:0] OP_MFLO = 5'd25;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_ROR = 4'd6;
   localparam logic [3:0] ALU_ROL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;
   localparam logic [3:0] ALU_NEG = 4'd10;
   localparam logic [3:0] ALU_NOT = 4'd11;

   localparam logic [3:0] ST_T0   = 4'd0;
   localparam logic [3:0] ST_T1   = 4'd1;
   localparam logic [3:0] ST_T2   = 4'd2;
   localparam logic [3:0] ST_T3   = 4'd3;
   localparam logic [3:0] ST_T4   = 4'd4;
   localparam logic [3:0] ST_T5   = 4'd5;
   localparam logic [3:0] ST_T6   = 4'd6;
   localparam logic [3:0] ST_T7   = 4'd7;
   localparam logic [3:0] ST_HALT = 4'd8;

   typedef struct packed {
      logic       pc_out;
      logic       inc_pc;
      logic       pc_in;
      logic       mar_in;
      logic       mdr_in;
      logic       mdr_read;
      logic       mdr_out;
      logic       ir_in;
      logic       y_in;
      logic       z_in;
      logic       zlow_out;
      logic       zhigh_out;
      logic       hi_in;
      logic       lo_in;
      logic       hi_out;
      logic       lo_out;
      logic       c_out;
      logic       inport_out;
      logic       mem_write;
      logic [3:0] alu_sel;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       rin_req;
      logic       rout_req;
      logic       ba;
   } strobe_t;

   function automatic logic is_imm(input logic [4:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   function automatic logic [3:0] alu_of_op(input logic [4:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR,  OP_ORI:  return ALU_OR;
         OP_SHR:          return ALU_SHR;
         OP_SHL:          return ALU_SHL;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_unit_sel_encode.sv
// Register-field selector: picks ra/rb/rc from the IR and expands it into the
// one-hot Rin/Rout enables, dropping Rout for a zero base register.
module sel_encode
   import cpu_pkg::*;
(
   input  logic [31:0] ir_i,
   input  logic        gra_i,
   input  logic        grb_i,
   input  logic        grc_i,
   input  logic        rin_i,
   input  logic        rout_i,
   input  logic        ba_i,
   output logic [15:0] rin_o,
   output logic [15:0] rout_o
);

   logic [3:0] sel;
   logic       base_zero;
   logic       unused_ir;

   always_comb begin
      sel = 4'd0;
      if (gra_i)      sel = ir_i[26:23];
      else if (grb_i) sel = ir_i[22:19];
      else if (grc_i) sel = ir_i[18:15];
   end

   // r0 used as a base means "no base": the address is C alone.
   assign base_zero = ba_i && (sel == 4'd0);

   assign rin_o     = rin_i ? (16'd1 << sel) : 16'd0;
   assign rout_o    = (rout_i && !base_zero) ? (16'd1 << sel) : 16'd0;
   assign unused_ir = ^{ir_i[31:27], ir_i[14:0]};

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle controller: step counter T0..T7/HALT plus a
// combinational decode of (step, IR) into every datapath strobe.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        stop,
   input  logic [31:0] ir,
   output logic        run,
   output logic        mem_write,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        IncPC,
   output logic        PCin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRread,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        ZIn,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        InPortout,
   output logic [3:0]  ALUselect,
   output logic [31:0] c_sign_extended
);

   logic [3:0] state_q, state_d;
   logic [4:0] op;
   strobe_t    ctl;

   assign op = ir[31:27];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= ST_T0;
      else     state_q <= state_d;
   end

   always_comb begin
      ctl     = '0;
      state_d = state_q;
      case (state_q)
         ST_T0: begin
            // A stop request wins over the fetch so the PC is left untouched.
            if (stop) begin
               state_d = ST_HALT;
            end else begin
               ctl.pc_out = 1'b1;
               ctl.mar_in = 1'b1;
               ctl.inc_pc = 1'b1;
               state_d    = ST_T1;
            end
         end
         ST_T1: begin
            ctl.mdr_read = 1'b1;
            ctl.mdr_in   = 1'b1;
            state_d      = ST_T2;
         end
         ST_T2: begin
            ctl.mdr_out = 1'b1;
            ctl.ir_in   = 1'b1;
            state_d     = ST_T3;
         end
         ST_HALT: state_d = ST_HALT;
         default: begin
            state_d = ST_T0;
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
               OP_ADDI, OP_ANDI, OP_ORI: begin
                  case (state_q)
                     ST_T3: begin
                        ctl.grb = 1'b1; ctl.rout_req = 1'b1; ctl.y_in = 1'b1;
                        state_d = ST_T4;
                     end
                     ST_T4: begin
                        if (is_imm(op)) ctl.c_out = 1'b1;
                        else begin ctl.grc = 1'b1; ctl.rout_req = 1'b1; end
                        ctl.alu_sel = alu_of_op(op);
                        ctl.z_in    = 1'b1;
                        state_d     = ST_T5;
                     end
                     ST_T5: begin
                        ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.rin_req = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_MUL, OP_DIV: begin
                  case (state_q)
                     ST_T3: begin
                        ctl.gra = 1'b1; ctl.rout_req = 1'b1; ctl.y_in = 1'b1;
                        state_d = ST_T4;
                     end
                     ST_T4: begin
                        ctl.grb = 1'b1; ctl.rout_req = 1'b1; ctl.z_in = 1'b1;
                        ctl.alu_sel = alu_of_op(op);
                        state_d = ST_T5;
                     end
                     ST_T5: begin
                        ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
                        state_d = ST_T6;
                     end
                     ST_T6: begin
                        ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_NEG, OP_NOT: begin
                  if (state_q == ST_T3) begin
                     ctl.grb = 1'b1; ctl.rout_req = 1'b1; ctl.z_in = 1'b1;
                     ctl.alu_sel = alu_of_op(op);
                     state_d = ST_T4;
                  end else if (state_q == ST_T4) begin
                     ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.rin_req = 1'b1;
                  end
               end
               OP_LD, OP_LDI, OP_ST: begin
                  case (state_q)
                     ST_T3: begin
                        ctl.grb = 1'b1; ctl.rout_req = 1'b1; ctl.ba = 1'b1;
                        ctl.y_in = 1'b1;
                        state_d = ST_T4;
                     end
                     ST_T4: begin
                        ctl.c_out = 1'b1; ctl.alu_sel = ALU_ADD; ctl.z_in = 1'b1;
                        state_d = ST_T5;
                     end
                     ST_T5: begin
                        ctl.zlow_out = 1'b1;
                        if (op == OP_LDI) begin
                           ctl.gra = 1'b1; ctl.rin_req = 1'b1;
                        end else begin
                           ctl.mar_in = 1'b1;
                           state_d    = ST_T6;
                        end
                     end
                     ST_T6: begin
                        ctl.mdr_in = 1'b1;
                        // Store loads MDR from the bus, so the memory read path stays off.
                        if (op == OP_ST) begin
                           ctl.gra = 1'b1; ctl.rout_req = 1'b1;
                        end else begin
                           ctl.mdr_read = 1'b1;
                        end
                        state_d = ST_T7;
                     end
                     ST_T7: begin
                        if (op == OP_ST) begin
                           ctl.mem_write = 1'b1;
                        end else begin
                           ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.rin_req = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
               OP_MFHI, OP_MFLO: begin
                  if (state_q == ST_T3) begin
                     ctl.hi_out  = (op == OP_MFHI);
                     ctl.lo_out  = (op == OP_MFLO);
                     ctl.gra     = 1'b1;
                     ctl.rin_req = 1'b1;
                  end
               end
               OP_JR: begin
                  if (state_q == ST_T3) begin
                     ctl.gra = 1'b1; ctl.rout_req = 1'b1; ctl.pc_in = 1'b1;
                  end
               end
               OP_IN: begin
                  if (state_q == ST_T3) begin
                     ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.rin_req = 1'b1;
                  end
               end
               OP_HALT: begin
                  if (state_q == ST_T3) state_d = ST_HALT;
               end
               default: ;
            endcase
         end
      endcase
      if (clr) ctl = '0;
   end

   sel_encode u_sel (
      .ir_i   (ir),
      .gra_i  (ctl.gra),
      .grb_i  (ctl.grb),
      .grc_i  (ctl.grc),
      .rin_i  (ctl.rin_req),
      .rout_i (ctl.rout_req),
      .ba_i   (ctl.ba),
      .rin_o  (Rin),
      .rout_o (Rout)
   );

   assign run             = (state_q != ST_HALT);
   assign mem_write       = ctl.mem_write;
   assign PCout           = ctl.pc_out;
   assign IncPC           = ctl.inc_pc;
   assign PCin            = ctl.pc_in;
   assign MARin           = ctl.mar_in;
   assign MDRin           = ctl.mdr_in;
   assign MDRread         = ctl.mdr_read;
   assign MDRout          = ctl.mdr_out;
   assign IRin            = ctl.ir_in;
   assign Yin             = ctl.y_in;
   assign ZIn             = ctl.z_in;
   assign ZLowout         = ctl.zlow_out;
   assign ZHighout        = ctl.zhigh_out;
   assign HIin            = ctl.hi_in;
   assign LOin            = ctl.lo_in;
   assign HIout           = ctl.hi_out;
   assign LOout           = ctl.lo_out;
   assign Cout            = ctl.c_out;
   assign InPortout       = ctl.inport_out;
   assign ALUselect       = ctl.alu_sel;
   assign c_sign_extended = {{13{ir[18]}}, ir[18:0]};

endmodule
